// File: rtl/pong_pkg.sv
// pong_pkg: shared match-state encoding, screen geometry, field widths and the level rule.
// level_of: min(max_lvl, (a + b) / step), with the sum taken 5 bits wide.
package pong_pkg;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} match_state_t;
  localparam int X_RESOLUTION = 640;
  localparam int Y_RESOLUTION = 480;
  localparam int SCORE_W = 4;
  localparam int LVL_W = 3;
  function automatic logic [LVL_W-1:0] level_of(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b,
                                                input int step, input int max_lvl);
    logic [4:0] sum;
    logic [4:0] q;
    sum = 5'(a) + 5'(b);
    q = 5'(int'(sum) / step);
    return (int'(q) > max_lvl) ? LVL_W'(max_lvl) : q[LVL_W-1:0];
  endfunction
endpackage

// File: rtl/match_controller_serve_timer.sv
// serve_timer: delay counter between a ball re-centre and the start of motion.
// Ports: clk, rst_n (async active-low), clr (sync clear), en (count), done (count == SERVE_DELAY-1).
module serve_timer #(
  parameter int SERVE_DELAY = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(SERVE_DELAY);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign done = count == W'(SERVE_DELAY - 1);
endmodule

// File: rtl/match_controller.sv
// match_controller: match-level FSM that serves the ball, tracks scores and level, and ends the match.
// Inputs: clk, reset (async active-low), start (debounced key), player1_point/player2_point (tracker goals).
// Outputs (all registered): game_on, ball_rst_n, dir, lvl, score1, score2, game_over, winner.
module match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = 7,
  parameter int SERVE_DELAY = 50_000_000,
  parameter int LVL_STEP = 2,
  parameter int MAX_LVL = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               player1_point,
  input  logic               player2_point,
  output logic               game_on,
  output logic               ball_rst_n,
  output logic               dir,
  output logic [LVL_W-1:0]   lvl,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic [1:0]         winner
);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  match_state_t state;
  logic start_q, p1_q, p2_q, timer_done;
  logic rise_start, rise_p1, rise_p2;
  assign rise_start = start & ~start_q;
  assign rise_p1 = player1_point & ~p1_q;
  assign rise_p2 = player2_point & ~p2_q;
  // ball_rst_n is low only in the first SERVE cycle, so it doubles as the entry marker
  serve_timer #(.SERVE_DELAY(SERVE_DELAY)) u_timer (
    .clk  (clk),
    .rst_n(reset),
    .clr  (state == SERVE && !ball_rst_n),
    .en   (state == SERVE && ball_rst_n),
    .done (timer_done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {start_q, p1_q, p2_q} <= '0;
      {game_on, ball_rst_n, dir, game_over} <= '0;
      lvl <= '0;
      score1 <= '0;
      score2 <= '0;
      winner <= '0;
    end else begin
      start_q <= start;
      p1_q <= player1_point;
      p2_q <= player2_point;
      case (state)
        IDLE: begin
          ball_rst_n <= !rise_start;
          state <= rise_start ? SERVE : IDLE;
        end
        SERVE: begin
          ball_rst_n <= 1'b1;
          if (ball_rst_n && timer_done) begin
            state <= PLAY;
            game_on <= 1'b1;
          end
        end
        PLAY: begin
          if (rise_p1 && rise_p2) begin
            state <= SERVE;
            game_on <= 1'b0;
            ball_rst_n <= 1'b0;
          end else if (rise_p1) begin
            state <= SCORED;
            game_on <= 1'b0;
            dir <= 1'b1;
            score1 <= (score1 == WIN) ? score1 : score1 + 1'b1;
          end else if (rise_p2) begin
            state <= SCORED;
            game_on <= 1'b0;
            dir <= 1'b0;
            score2 <= (score2 == WIN) ? score2 : score2 + 1'b1;
          end
        end
        SCORED: begin
          lvl <= level_of(score1, score2, LVL_STEP, MAX_LVL);
          if (score1 == WIN || score2 == WIN) begin
            state <= OVER;
            game_over <= 1'b1;
            winner <= (score1 == WIN) ? 2'b01 : 2'b10;
          end else begin
            state <= SERVE;
            ball_rst_n <= 1'b0;
          end
        end
        OVER: begin
          if (rise_start) begin
            state <= SERVE;
            ball_rst_n <= 1'b0;
            score1 <= '0;
            score2 <= '0;
            lvl <= '0;
            winner <= '0;
            game_over <= 1'b0;
            dir <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: randomized rallies scored by a reference model; a monitor checks each serve and match end.
module tb_match_controller;
  localparam int WIN = 3;
  localparam int DELAY = 4;
  localparam int STEP = 2;
  localparam int MAXL = 7;
  logic clk = 0, reset, start, p1, p2;
  logic game_on, ball_rst_n, dir, game_over;
  logic [2:0] lvl;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  always #5 clk = ~clk;
  match_controller #(.WIN_SCORE(WIN), .SERVE_DELAY(DELAY), .LVL_STEP(STEP), .MAX_LVL(MAXL)) dut (
    .clk(clk), .reset(reset), .start(start), .player1_point(p1), .player2_point(p2),
    .game_on(game_on), .ball_rst_n(ball_rst_n), .dir(dir), .lvl(lvl), .score1(score1),
    .score2(score2), .game_over(game_over), .winner(winner)
  );
  typedef struct {
    bit over;
    int s1, s2, lvl, dir, win;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int s1 = 0, s2 = 0, mdir = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask
  function automatic int model_lvl(input int a, input int b);
    return ((a + b) / STEP > MAXL) ? MAXL : (a + b) / STEP;
  endfunction
  task automatic push(input bit over);
    exp_t e;
    e.over = over;
    e.s1 = s1;
    e.s2 = s2;
    e.lvl = model_lvl(s1, s2);
    e.dir = mdir;
    e.win = (s1 == WIN) ? 1 : (s2 == WIN) ? 2 : 0;
    q.push_back(e);
  endtask
  task automatic wait_on(input string name, input bit want_go);
    int n = 0;
    while (!(want_go ? game_on : game_over)) begin
      @(negedge clk);
      n++;
      if (n > 60) begin
        chk({name, "_timeout"}, 0, 1);
        summary();
      end
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_game_on"}, game_on, 0);
    chk({tag, "_ball_rst_n"}, ball_rst_n, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_lvl"}, lvl, 0);
    chk({tag, "_score1"}, score1, 0);
    chk({tag, "_score2"}, score2, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask
  task automatic press_start();
    s1 = 0;
    s2 = 0;
    mdir = 0;
    push(0);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  // kind: 0 player 1 scores, 1 player 2 scores, 2 both goals rise together
  task automatic point(input int kind, input int hold);
    if (kind == 0) begin
      s1++;
      mdir = 1;
    end else if (kind == 1) begin
      s2++;
      mdir = 0;
    end
    push(s1 == WIN || s2 == WIN);
    p1 = (kind != 1);
    p2 = (kind != 0);
    repeat (hold) @(negedge clk);
    p1 = 0;
    p2 = 0;
    @(negedge clk);
  endtask
  task automatic play_match();
    while (s1 != WIN && s2 != WIN) begin
      wait_on("game_on", 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        start = 1;
        @(negedge clk);
        start = 0;
      end
      point(($urandom_range(0, 4) == 4) ? 2 : int'($urandom_range(0, 1)), $urandom_range(1, 10));
    end
    wait_on("game_over", 0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    chk("over_hold_game_on", game_on, 0);
    chk("over_hold_ball_rst_n", ball_rst_n, 1);
  endtask
  // Monitor: every ball_rst_n fall and every game_over rise consumes one expected event.
  bit prev_brst, prev_go, prev_gov, armed;
  int since;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      {prev_brst, prev_go, prev_gov, armed} = '0;
      since = 0;
    end else begin
      if (armed) begin
        since++;
        if (since == 1) chk("pulse_width", ball_rst_n, 1);
      end
      if (prev_brst && !ball_rst_n) begin
        armed = 1;
        since = 0;
        if (q.size() == 0) chk("serve_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("serve_kind", 0, int'(e.over));
          chk("serve_score1", score1, e.s1);
          chk("serve_score2", score2, e.s2);
          chk("serve_lvl", lvl, e.lvl);
          chk("serve_dir", dir, e.dir);
          chk("serve_game_on", game_on, 0);
        end
      end
      if (!prev_go && game_on) begin
        chk("serve_armed", armed, 1);
        chk("serve_delay", since, DELAY + 1);
        armed = 0;
      end
      if (!prev_gov && game_over) begin
        if (q.size() == 0) chk("over_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("over_kind", 1, int'(e.over));
          chk("over_winner", winner, e.win);
          chk("over_score1", score1, e.s1);
          chk("over_score2", score2, e.s2);
          chk("over_lvl", lvl, e.lvl);
          chk("over_game_on", game_on, 0);
        end
      end
      prev_brst = ball_rst_n;
      prev_go = game_on;
      prev_gov = game_over;
    end
  end
  initial begin
    reset = 1;
    start = 0;
    p1 = 0;
    p2 = 0;
    #3 reset = 0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #2 reset = 1;
    repeat (2) @(negedge clk);
    chk("idle_ball_rst_n", ball_rst_n, 1);
    chk("idle_game_on", game_on, 0);
    for (int m = 0; m < 5; m++) begin
      press_start();
      play_match();
    end
    press_start();
    wait_on("game_on", 1);
    point(0, 10);
    wait_on("game_on", 1);
    point(2, 2);
    wait_on("game_on", 1);
    point(0, 3);
    wait_on("game_on", 1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    chk("play_start_game_on", game_on, 1);
    chk("play_start_ball_rst_n", ball_rst_n, 1);
    chk("play_score1", score1, 2);
    chk("play_queue_empty", q.size(), 0);
    @(posedge clk);
    #2 reset = 0;
    #1 chk_reset("mid_play");
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    repeat (3) @(negedge clk);
    chk("post_reset_ball_rst_n", ball_rst_n, 1);
    chk("post_reset_score1", score1, 0);
    chk("post_reset_game_on", game_on, 0);
    summary();
  end
endmodule
